// File: rtl/uart_tx_axi.sv
// rtl/uart_tx_axi.sv - AXI4-lite write master handing one byte at a time to the UART Lite TX FIFO
// Define UART_TX_STATUS_POLL_EN to poll the status register for TX FIFO room before every write.
module uart_tx_axi #(
    parameter logic [3:0] TX_ADDR    = 4'h4,
    parameter logic [3:0] STAT_ADDR  = 4'h8,
    parameter int         TXFULL_BIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  uart_axi_awaddr,
    output logic        uart_axi_awvalid,
    input  logic        uart_axi_awready,
    output logic [31:0] uart_axi_wdata,
    output logic [3:0]  uart_axi_wstrb,
    output logic        uart_axi_wvalid,
    input  logic        uart_axi_wready,
    input  logic [1:0]  uart_axi_bresp,
    input  logic        uart_axi_bvalid,
    output logic        uart_axi_bready,
    output logic [3:0]  uart_axi_araddr,
    output logic        uart_axi_arvalid,
    input  logic        uart_axi_arready,
    input  logic [31:0] uart_axi_rdata,
    input  logic [1:0]  uart_axi_rresp,
    input  logic        uart_axi_rvalid,
    output logic        uart_axi_rready,
    input  logic [7:0]  data,
    input  logic        en,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, STAT_AR, STAT_R, WRITE, RESP} state_t;

    state_t     state;
    logic [7:0] byte_q;

    assign uart_axi_awaddr = TX_ADDR;
    assign uart_axi_wdata  = {24'h0, byte_q};
    assign uart_axi_wstrb  = 4'b0001;
    assign uart_axi_araddr = STAT_ADDR;

    // Only the full bit of the status word matters; the rest is deliberately ignored.
    logic unused_status;
    assign unused_status = ^{uart_axi_rdata, uart_axi_rresp, uart_axi_arready, uart_axi_rvalid};

`ifdef UART_TX_STATUS_POLL_EN
    logic arvalid_q;
    logic rready_q;
    assign uart_axi_arvalid = arvalid_q;
    assign uart_axi_rready  = rready_q;
`else
    assign uart_axi_arvalid = 1'b0;
    assign uart_axi_rready  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            byte_q           <= 8'h00;
            uart_axi_awvalid <= 1'b0;
            uart_axi_wvalid  <= 1'b0;
            uart_axi_bready  <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
`ifdef UART_TX_STATUS_POLL_EN
            arvalid_q        <= 1'b0;
            rready_q         <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        byte_q <= data;
                        busy   <= 1'b1;
                        err    <= 1'b0;
`ifdef UART_TX_STATUS_POLL_EN
                        arvalid_q <= 1'b1;
                        state     <= STAT_AR;
`else
                        uart_axi_awvalid <= 1'b1;
                        uart_axi_wvalid  <= 1'b1;
                        state            <= WRITE;
`endif
                    end
                end
`ifdef UART_TX_STATUS_POLL_EN
                STAT_AR: begin
                    if (arvalid_q && uart_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= STAT_R;
                    end
                end
                STAT_R: begin
                    if (uart_axi_rvalid && rready_q) begin
                        rready_q <= 1'b0;
                        // A failed status read is treated like a full FIFO: ask again.
                        if (uart_axi_rresp != 2'b00 || uart_axi_rdata[TXFULL_BIT]) begin
                            arvalid_q <= 1'b1;
                            state     <= STAT_AR;
                        end else begin
                            uart_axi_awvalid <= 1'b1;
                            uart_axi_wvalid  <= 1'b1;
                            state            <= WRITE;
                        end
                    end
                end
`endif
                WRITE: begin
                    if (uart_axi_awready) uart_axi_awvalid <= 1'b0;
                    if (uart_axi_wready)  uart_axi_wvalid  <= 1'b0;
                    // Each channel is finished if already dropped or handshaking now.
                    if ((!uart_axi_awvalid || uart_axi_awready) &&
                        (!uart_axi_wvalid  || uart_axi_wready)) begin
                        uart_axi_bready <= 1'b1;
                        state           <= RESP;
                    end
                end
                RESP: begin
                    if (uart_axi_bvalid && uart_axi_bready) begin
                        uart_axi_bready <= 1'b0;
                        busy            <= 1'b0;
                        done            <= 1'b1;
                        err             <= (uart_axi_bresp != 2'b00);
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
